// File: rtl/dot_fp_acc_ctrl_pkg.sv
// Shared types and width helpers for the block-streaming dot_fp accumulator.
// Upstream and downstream blocks call the same helpers so their ports match.
package dot_fp_acc_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Sign + exponent + mantissa.
    function automatic int bit_width_f(input int e_w, input int m_w);
        return 1 + e_w + m_w;
    endfunction

    // One operand magnitude expanded to an unsigned fixed-point integer whose
    // LSB is the smallest subnormal step.
    function automatic int fix_width_f(input int e_w, input int m_w);
        return m_w + 1 + (1 << e_w) - 2;
    endfunction

    // Signed fixed-point width of one lane product.
    function automatic int prd_width_f(input int e_w, input int m_w);
        return 2 * ((1 << e_w) + m_w);
    endfunction

    // Width of the sum of all lane products of one block.
    function automatic int out_width_f(input int e_w, input int m_w, input int lanes);
        return prd_width_f(e_w, m_w) + $clog2(lanes);
    endfunction

    // Accumulator wide enough that the longest legal job cannot overflow.
    function automatic int acc_width_f(input int e_w, input int m_w, input int lanes,
                                       input int blocks);
        return out_width_f(e_w, m_w, lanes) + $clog2(blocks);
    endfunction

    // Holds every count from 0 up to and including the largest legal N.
    function automatic int cnt_width_f(input int blocks);
        return $clog2(blocks + 1);
    endfunction

endpackage

// File: rtl/dot_fp_acc_ctrl_if.sv
// Control, operand-block and result handshakes of the dot_fp accumulator.
// master = operand front end / result consumer, slave = the accumulator.
interface dot_fp_acc_ctrl_if #(
    parameter int exp_width  = 5,
    parameter int man_width  = 2,
    parameter int k          = 32,
    parameter int max_blocks = 64
);
    import dot_fp_acc_ctrl_pkg::*;

    localparam int bit_width = bit_width_f(exp_width, man_width);
    localparam int acc_width = acc_width_f(exp_width, man_width, k, max_blocks);
    localparam int cnt_width = cnt_width_f(max_blocks);

    logic                          start;
    logic [cnt_width-1:0]          num_blocks;
    logic                          busy;
    logic                          err;
    logic                          blk_valid;
    logic                          blk_ready;
    logic [k-1:0][bit_width-1:0]   vec_a;
    logic [k-1:0][bit_width-1:0]   vec_b;
    logic                          res_valid;
    logic                          res_ready;
    logic signed [acc_width-1:0]   acc;

    modport master (
        output start, num_blocks, blk_valid, vec_a, vec_b, res_ready,
        input  busy, err, blk_ready, res_valid, acc
    );

    modport slave (
        input  start, num_blocks, blk_valid, vec_a, vec_b, res_ready,
        output busy, err, blk_ready, res_valid, acc
    );

endinterface

// File: rtl/dot_fp_acc_ctrl_dot_fp.sv
// Combinational k-wide minifloat dot product. Each operand is expanded to an
// exact fixed-point integer, so the result is the exact sum of lane products.
module dot_fp_acc_ctrl_dot_fp #(
    parameter int    exp_width = 5,
    parameter int    man_width = 2,
    parameter int    k         = 32,
    parameter string USE_DSP   = "auto",
    localparam int   bit_width = dot_fp_acc_ctrl_pkg::bit_width_f(exp_width, man_width),
    localparam int   out_width = dot_fp_acc_ctrl_pkg::out_width_f(exp_width, man_width, k)
) (
    input  logic [k-1:0][bit_width-1:0] vec_a,
    input  logic [k-1:0][bit_width-1:0] vec_b,
    output logic signed [out_width-1:0] dp
);
    import dot_fp_acc_ctrl_pkg::*;

    localparam int fix_width = fix_width_f(exp_width, man_width);
    localparam int prd_width = prd_width_f(exp_width, man_width);
    localparam int sig_width = man_width + 1;

    logic signed [prd_width-1:0] prod [k];

    for (genvar i = 0; i < k; i++) begin : g_lane
        logic                 sign_a;
        logic                 sign_b;
        logic [exp_width-1:0] exp_a;
        logic [exp_width-1:0] exp_b;
        logic [sig_width-1:0] sig_a;
        logic [sig_width-1:0] sig_b;
        logic [exp_width-1:0] sh_a;
        logic [exp_width-1:0] sh_b;
        logic [prd_width-1:0] mag;

        // Subnormals (exponent 0) have no hidden one and share the scale of
        // exponent 1, hence the shift of exponent minus one for normals.
        assign sign_a = vec_a[i][bit_width-1];
        assign sign_b = vec_b[i][bit_width-1];
        assign exp_a  = vec_a[i][bit_width-2 -: exp_width];
        assign exp_b  = vec_b[i][bit_width-2 -: exp_width];
        assign sig_a  = {exp_a != '0, vec_a[i][man_width-1:0]};
        assign sig_b  = {exp_b != '0, vec_b[i][man_width-1:0]};
        assign sh_a   = (exp_a == '0) ? '0 : exp_a - exp_width'(1);
        assign sh_b   = (exp_b == '0) ? '0 : exp_b - exp_width'(1);

        if (USE_DSP == "no") begin : g_shift
            // Small significand multiply, then one shift by the summed exponents.
            logic [2*sig_width-1:0] sig_prd;
            logic [exp_width:0]     sh_sum;

            assign sig_prd = (2*sig_width)'(sig_a) * (2*sig_width)'(sig_b);
            assign sh_sum  = {1'b0, sh_a} + {1'b0, sh_b};
            assign mag     = prd_width'(sig_prd) << sh_sum;
        end else begin : g_mult
            // Full-width multiply of the expanded operands, suited to DSP blocks.
            logic [fix_width-1:0] fix_a;
            logic [fix_width-1:0] fix_b;

            assign fix_a = fix_width'(sig_a) << sh_a;
            assign fix_b = fix_width'(sig_b) << sh_b;
            assign mag   = prd_width'(fix_a) * prd_width'(fix_b);
        end

        assign prod[i] = (sign_a ^ sign_b) ? -$signed(mag) : $signed(mag);
    end

    // Sign-extend every lane product and add them into the block result.
    always_comb begin
        dp = '0;
        for (int i = 0; i < k; i++) begin
            dp = dp + out_width'(prod[i]);
        end
    end

endmodule

// File: rtl/dot_fp_acc_ctrl.sv
// Runs one dot_fp over N operand blocks, registers each block result and
// accumulates all of them, then offers the sum on a result handshake.
module dot_fp_acc_ctrl #(
    parameter int    exp_width  = 5,
    parameter int    man_width  = 2,
    parameter int    k          = 32,
    parameter int    max_blocks = 64,
    parameter string USE_DSP    = "auto"
) (
    input  logic                 clk,
    input  logic                 rst,
    dot_fp_acc_ctrl_if.slave     bus
);
    import dot_fp_acc_ctrl_pkg::*;

    localparam int out_width = out_width_f(exp_width, man_width, k);
    localparam int acc_width = acc_width_f(exp_width, man_width, k, max_blocks);
    localparam int cnt_width = cnt_width_f(max_blocks);

    state_t                      state_q;
    state_t                      state_d;
    logic [cnt_width-1:0]        num_q;
    logic [cnt_width-1:0]        count_q;
    logic signed [out_width-1:0] dp;
    logic signed [out_width-1:0] p1_dp;
    logic                        p1_vld;
    logic signed [acc_width-1:0] acc_q;
    logic                        err_q;
    logic                        start_ok;
    logic                        job_start;
    logic                        beat;
    logic                        last_beat;

    assign start_ok  = (bus.num_blocks != '0) && (bus.num_blocks <= cnt_width'(max_blocks));
    assign job_start = (state_q == IDLE) && bus.start && start_ok;
    assign beat      = bus.blk_valid && (state_q == RUN);
    assign last_beat = beat && (count_q == num_q - cnt_width'(1));

    assign bus.busy      = (state_q != IDLE);
    assign bus.err       = err_q;
    assign bus.blk_ready = (state_q == RUN);
    assign bus.res_valid = (state_q == DONE);
    assign bus.acc       = acc_q;

    dot_fp_acc_ctrl_dot_fp #(
        .exp_width (exp_width),
        .man_width (man_width),
        .k         (k),
        .USE_DSP   (USE_DSP)
    ) u_dot_fp (
        .vec_a (bus.vec_a),
        .vec_b (bus.vec_b),
        .dp    (dp)
    );

    // Job state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Job sequencing: accept N beats, let the last partial land, hand off.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (job_start) state_d = RUN;
            RUN:     if (last_beat) state_d = DRAIN;
            DRAIN:   if (!p1_vld) state_d = DONE;
            DONE:    if (bus.res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Latch the job length on start and count accepted beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_q   <= '0;
            count_q <= '0;
        end else if (job_start) begin
            num_q   <= bus.num_blocks;
            count_q <= '0;
        end else if (beat) begin
            count_q <= count_q + cnt_width'(1);
        end
    end

    // One-cycle error pulse when a start asks for an illegal block count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (state_q == IDLE) && bus.start && !start_ok;
        end
    end

    // Register each accepted block's dot product before it is accumulated.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p1_vld <= 1'b0;
            p1_dp  <= '0;
        end else begin
            p1_vld <= beat;
            if (beat) begin
                p1_dp <= dp;
            end
        end
    end

    // Accumulate sign-extended partials; cleared at the start of every job.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (job_start) begin
            acc_q <= '0;
        end else if (p1_vld) begin
            acc_q <= acc_q + acc_width'(p1_dp);
        end
    end

endmodule

// File: tb/tb_dot_fp_acc_ctrl.sv
// Self-checking bench for dot_fp_acc_ctrl with E5M2 operands, k=4, max_blocks=8.
module tb_dot_fp_acc_ctrl;
    import dot_fp_acc_ctrl_pkg::*;

    localparam int EXP_W = 5;
    localparam int MAN_W = 2;
    localparam int K     = 4;
    localparam int MAX_B = 8;
    localparam int BIT_W = bit_width_f(EXP_W, MAN_W);
    localparam int ACC_W = acc_width_f(EXP_W, MAN_W, K, MAX_B);
    localparam int CNT_W = cnt_width_f(MAX_B);
    localparam int N_VEC = 10;

    typedef logic [K-1:0][BIT_W-1:0] vec_t;
    typedef logic signed [ACC_W-1:0] acc_t;
    typedef logic signed [127:0]     big_t;

    typedef struct packed {
        vec_t a;
        vec_t b;
        acc_t exp_acc;
    } vector_t;

    logic    clk = 1'b0;
    logic    rst;
    int      checks = 0;
    int      errors = 0;
    vec_t    job_a [MAX_B];
    vec_t    job_b [MAX_B];
    vector_t table_v [N_VEC];

    dot_fp_acc_ctrl_if #(
        .exp_width  (EXP_W),
        .man_width  (MAN_W),
        .k          (K),
        .max_blocks (MAX_B)
    ) bus ();

    dot_fp_acc_ctrl #(
        .exp_width  (EXP_W),
        .man_width  (MAN_W),
        .k          (K),
        .max_blocks (MAX_B),
        .USE_DSP    ("auto")
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: summary not reached in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Real value of an E5M2 operand in units of the smallest subnormal step.
    function automatic big_t fp_val(input logic [BIT_W-1:0] x);
        int   e;
        int   m;
        big_t mag;
        e = int'(x[BIT_W-2 -: EXP_W]);
        m = int'(x[MAN_W-1:0]);
        if (e == 0) mag = big_t'(m);
        else        mag = big_t'((1 << MAN_W) + m) <<< (e - 1);
        return x[BIT_W-1] ? -mag : mag;
    endfunction

    // Exact sum over all blocks and lanes of the current job.
    function automatic acc_t model_job(input int n);
        big_t total;
        total = '0;
        for (int b = 0; b < n; b++) begin
            for (int l = 0; l < K; l++) begin
                total = total + fp_val(job_a[b][l]) * fp_val(job_b[b][l]);
            end
        end
        return acc_t'(total);
    endfunction

    function automatic vec_t splat(input logic [BIT_W-1:0] x);
        return {K{x}};
    endfunction

    function automatic vec_t one_lane(input logic [BIT_W-1:0] x);
        vec_t v;
        v    = '0;
        v[0] = x;
        return v;
    endfunction

    task automatic check_output(input string name, input big_t act, input big_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic apply_stimulus(input int n);
        bus.num_blocks = CNT_W'(n);
        bus.start      = 1'b1;
        tick();
        bus.start      = 1'b0;
    endtask

    task automatic send_block(input vec_t a, input vec_t b, input int gap, input string tag);
        int tries;
        bit taken;
        repeat (gap) tick();
        bus.blk_valid = 1'b1;
        bus.vec_a     = a;
        bus.vec_b     = b;
        taken = 1'b0;
        tries = 0;
        while (!taken && tries < 20) begin
            @(negedge clk);
            taken = bus.blk_ready;
            @(posedge clk);
            #1;
            tries++;
        end
        bus.blk_valid = 1'b0;
        if (!taken) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s block_accept: got no ready, expected ready within 20 cycles", tag);
        end
    endtask

    // Called right after the last beat's edge; counts edges until res_valid.
    task automatic wait_result(input string tag, output int lat, output bit ok);
        lat = 0;
        @(negedge clk);
        check_output({tag, " drain_ready"}, bus.blk_ready, 0);
        while (!bus.res_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            @(negedge clk);
        end
        ok = bus.res_valid;
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s result_timeout: got no res_valid, expected it within 20 cycles", tag);
        end
    endtask

    task automatic run_job(input int n, input acc_t expv, input int max_gap, input string tag);
        int lat;
        bit ok;
        apply_stimulus(n);
        for (int i = 0; i < n; i++) begin
            send_block(job_a[i], job_b[i],
                       (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0, tag);
        end
        wait_result(tag, lat, ok);
        if (ok) begin
            check_output({tag, " acc"}, bus.acc, expv);
            check_output({tag, " latency"}, lat, 2);
            tick();
            @(negedge clk);
            check_output({tag, " valid_drop"}, bus.res_valid, 0);
            @(posedge clk);
            #1;
        end else begin
            reset_dut();
        end
    endtask

    task automatic reject_start(input int n, input string tag);
        apply_stimulus(n);
        @(negedge clk);
        check_output({tag, " err_pulse"}, bus.err, 1);
        check_output({tag, " busy"}, bus.busy, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_output({tag, " err_clear"}, bus.err, 0);
        check_output({tag, " busy_after"}, bus.busy, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        acc_t p;
        int   lat;
        bit   ok;

        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.num_blocks = '0;
        bus.blk_valid  = 1'b0;
        bus.vec_a      = '0;
        bus.vec_b      = '0;
        bus.res_ready  = 1'b1;

        p = acc_t'(1) <<< 32;
        table_v[0] = '{a: splat(8'h00),    b: splat(8'h00),    exp_acc: acc_t'(0)};
        table_v[1] = '{a: one_lane(8'h3C), b: one_lane(8'h3C), exp_acc: p};
        table_v[2] = '{a: splat(8'h3C),    b: splat(8'h3C),    exp_acc: p <<< 2};
        table_v[3] = '{a: splat(8'h3C),    b: splat(8'hBC),    exp_acc: -(p <<< 2)};
        table_v[4] = '{a: splat(8'h40),    b: splat(8'h3C),    exp_acc: p <<< 3};
        table_v[5] = '{a: one_lane(8'h01), b: one_lane(8'h01), exp_acc: acc_t'(1)};
        table_v[6] = '{a: one_lane(8'h7B), b: one_lane(8'h7B), exp_acc: acc_t'(49) <<< 58};
        table_v[7] = '{a: {8'h00, 8'h40, 8'hBC, 8'h3C},
                       b: {8'h00, 8'h40, 8'h3C, 8'h3C},        exp_acc: p <<< 2};
        table_v[8] = '{a: one_lane(8'h03), b: one_lane(8'h04), exp_acc: acc_t'(12)};
        table_v[9] = '{a: one_lane(8'h83), b: one_lane(8'h04), exp_acc: -acc_t'(12)};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("reset busy", bus.busy, 0);
        check_output("reset err", bus.err, 0);
        check_output("reset blk_ready", bus.blk_ready, 0);
        check_output("reset res_valid", bus.res_valid, 0);
        check_output("reset acc", bus.acc, 0);
        rst = 1'b0;
        tick();

        $display("[TB] single-block vector table");
        for (int i = 0; i < N_VEC; i++) begin
            job_a[0] = table_v[i].a;
            job_b[0] = table_v[i].b;
            run_job(1, table_v[i].exp_acc, 0, $sformatf("vec%0d", i));
        end

        $display("[TB] three blocks back to back");
        for (int i = 0; i < 3; i++) begin
            job_a[i] = splat(8'h3C);
            job_b[i] = splat(8'h3C);
        end
        run_job(3, acc_t'(12) <<< 32, 0, "t1");

        $display("[TB] cancelling blocks with valid gaps");
        job_a[0] = splat(8'h3C);
        job_b[0] = splat(8'h3C);
        job_a[1] = splat(8'hBC);
        job_b[1] = splat(8'h3C);
        run_job(2, acc_t'(0), 3, "t2");

        $display("[TB] illegal block counts");
        reject_start(0, "t3_n0");
        reject_start(MAX_B + 1, "t3_n9");
        job_a[0] = '0;
        job_b[0] = '0;
        run_job(1, acc_t'(0), 0, "t3_zero");

        $display("[TB] result back-pressure");
        job_a[0] = splat(8'h3C);
        job_b[0] = one_lane(8'h3C);
        bus.res_ready = 1'b0;
        apply_stimulus(1);
        send_block(job_a[0], job_b[0], 0, "t4");
        wait_result("t4", lat, ok);
        if (ok) begin
            for (int c = 0; c < 5; c++) begin
                @(posedge clk);
                #1;
                bus.start      = (c % 2 == 0);
                bus.num_blocks = CNT_W'(3);
                @(negedge clk);
                check_output($sformatf("t4 hold_valid%0d", c), bus.res_valid, 1);
                check_output($sformatf("t4 hold_acc%0d", c), bus.acc, p);
            end
            @(posedge clk);
            #1;
            bus.start     = 1'b1;
            bus.res_ready = 1'b1;
            tick();
            bus.start     = 1'b0;
            @(negedge clk);
            check_output("t4 released_valid", bus.res_valid, 0);
            check_output("t4 start_ignored", bus.busy, 0);
            check_output("t4 no_err", bus.err, 0);
            @(posedge clk);
            #1;
        end else begin
            bus.res_ready = 1'b1;
            reset_dut();
        end

        $display("[TB] reset in the middle of a job");
        for (int i = 0; i < 4; i++) begin
            job_a[i] = splat(8'h3C);
            job_b[i] = splat(8'h3C);
        end
        apply_stimulus(4);
        send_block(job_a[0], job_b[0], 0, "t5");
        send_block(job_a[1], job_b[1], 0, "t5");
        #2;
        rst = 1'b1;
        #1;
        check_output("t5 rst busy", bus.busy, 0);
        check_output("t5 rst blk_ready", bus.blk_ready, 0);
        check_output("t5 rst res_valid", bus.res_valid, 0);
        check_output("t5 rst err", bus.err, 0);
        check_output("t5 rst acc", bus.acc, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        run_job(1, p <<< 2, 0, "t5_after");

        $display("[TB] longest job with largest operands");
        for (int i = 0; i < MAX_B; i++) begin
            job_a[i] = splat(8'h7B);
            job_b[i] = splat(8'h7B);
        end
        run_job(MAX_B, acc_t'(49) <<< 63, 0, "t6");

        $display("[TB] random jobs against the reference model");
        for (int j = 0; j < 8; j++) begin
            int n;
            n = int'($urandom_range(1, MAX_B));
            for (int i = 0; i < n; i++) begin
                for (int l = 0; l < K; l++) begin
                    job_a[i][l] = 8'($urandom);
                    job_b[i][l] = 8'($urandom);
                end
            end
            run_job(n, model_job(n), 2, $sformatf("rand%0d", j));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
